// File: rtl/morse_receptor.sv
// Morse line receiver: times marks and spaces in unit ticks, assembles dot/dash
// symbols and emits one ASCII character (or '?' with err) per completed symbol.
module morse_receptor #(
  parameter int UNIT_CLKS = 5000000,
  parameter int DASH_MIN  = 2,
  parameter int CHAR_GAP  = 2,
  parameter int WORD_GAP  = 5
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       key_in,
  output logic [7:0] char_out,
  output logic       char_valid,
  output logic       err,
  output logic       busy
);

  localparam int              PW      = (UNIT_CLKS > 1) ? $clog2(UNIT_CLKS) : 1;
  localparam logic [PW-1:0]   PRE_MAX = PW'(UNIT_CLKS - 1);
  localparam logic [2:0]      DASH3   = 3'(DASH_MIN);
  localparam logic [2:0]      CG3     = 3'(CHAR_GAP);
  localparam logic [2:0]      WG3     = 3'(WORD_GAP);

  typedef enum logic [1:0] {IDLE, MARK, GAP, WGAP} state_t;

  state_t        state_q, state_d;
  logic          key_q;
  logic [PW-1:0] pre_q, pre_d;
  logic [2:0]    len_q, len_d, len_inc;
  logic [4:0]    pat_q, pat_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    char_q, char_d;
  logic          vld_q, vld_d;
  logic          err_q, err_d;
  logic          rise, fall, tick;

  function automatic logic [2:0] sat_inc3(input logic [2:0] v);
    return (v == 3'd7) ? v : v + 3'd1;
  endfunction

  // Returns {err, ascii}; pattern is left-justified, MSB is the first element.
  function automatic logic [8:0] decode(input logic [2:0] n, input logic [4:0] p,
                                        input logic o);
    logic [7:0] c;
    c = 8'h3F;
    case ({n, p})
      {3'd2, 5'b01000}: c = 8'h41; {3'd4, 5'b10000}: c = 8'h42;
      {3'd4, 5'b10100}: c = 8'h43; {3'd3, 5'b10000}: c = 8'h44;
      {3'd1, 5'b00000}: c = 8'h45; {3'd4, 5'b00100}: c = 8'h46;
      {3'd3, 5'b11000}: c = 8'h47; {3'd4, 5'b00000}: c = 8'h48;
      {3'd2, 5'b00000}: c = 8'h49; {3'd4, 5'b01110}: c = 8'h4A;
      {3'd3, 5'b10100}: c = 8'h4B; {3'd4, 5'b01000}: c = 8'h4C;
      {3'd2, 5'b11000}: c = 8'h4D; {3'd2, 5'b10000}: c = 8'h4E;
      {3'd3, 5'b11100}: c = 8'h4F; {3'd4, 5'b01100}: c = 8'h50;
      {3'd4, 5'b11010}: c = 8'h51; {3'd3, 5'b01000}: c = 8'h52;
      {3'd3, 5'b00000}: c = 8'h53; {3'd1, 5'b10000}: c = 8'h54;
      {3'd3, 5'b00100}: c = 8'h55; {3'd4, 5'b00010}: c = 8'h56;
      {3'd3, 5'b01100}: c = 8'h57; {3'd4, 5'b10010}: c = 8'h58;
      {3'd4, 5'b10110}: c = 8'h59; {3'd4, 5'b11000}: c = 8'h5A;
      {3'd5, 5'b11111}: c = 8'h30; {3'd5, 5'b01111}: c = 8'h31;
      {3'd5, 5'b00111}: c = 8'h32; {3'd5, 5'b00011}: c = 8'h33;
      {3'd5, 5'b00001}: c = 8'h34; {3'd5, 5'b00000}: c = 8'h35;
      {3'd5, 5'b10000}: c = 8'h36; {3'd5, 5'b11000}: c = 8'h37;
      {3'd5, 5'b11100}: c = 8'h38; {3'd5, 5'b11110}: c = 8'h39;
      default:          c = 8'h3F;
    endcase
    if (o) c = 8'h3F;
    return {(c == 8'h3F), c};
  endfunction

  // Timing: a tick that lands on an edge still counts toward the closing run.
  always_comb begin
    rise    = key_in & ~key_q;
    fall    = ~key_in & key_q;
    tick    = (pre_q == PRE_MAX);
    len_inc = tick ? sat_inc3(len_q) : len_q;
    pre_d   = (rise || fall || tick) ? '0 : pre_q + PW'(1);
    len_d   = (rise || fall) ? 3'd0 : len_inc;
  end

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    char_d  = char_q;
    vld_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: if (rise) state_d = MARK;
      MARK: begin
        if (fall) begin
          if (len_inc == 3'd0) begin
            state_d = (cnt_q != 3'd0) ? GAP : IDLE;
          end else begin
            if (cnt_q < 3'd5) begin
              pat_d[3'd4 - cnt_q] = (len_inc >= DASH3);
              cnt_d = cnt_q + 3'd1;
            end else begin
              ovf_d = 1'b1;
            end
            state_d = GAP;
          end
        end
      end
      GAP: begin
        if (tick && len_inc == CG3) begin
          {err_d, char_d} = decode(cnt_q, pat_q, ovf_q);
          vld_d   = 1'b1;
          pat_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = rise ? MARK : WGAP;
        end else if (rise) begin
          state_d = MARK;
        end
      end
      WGAP: begin
        if (rise) begin
          state_d = MARK;
        end else if (tick && len_inc == WG3) begin
          char_d  = 8'h20;
          vld_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= IDLE;
      key_q   <= 1'b1;
      pre_q   <= '0;
      len_q   <= '0;
      pat_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      char_q  <= 8'h00;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_in;
      pre_q   <= pre_d;
      len_q   <= len_d;
      pat_q   <= pat_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      char_q  <= char_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
    end
  end

  assign char_out   = char_q;
  assign char_valid = vld_q;
  assign err        = err_q;
  assign busy       = (state_q == MARK) || (state_q == GAP);

endmodule

// File: tb/tb_morse_receptor.sv
// Scoreboard bench: a run-length Morse model predicts characters, separators and
// their arrival cycle; a monitor pops and compares on every char_valid pulse.
module tb_morse_receptor;
  localparam int U = 4, DM = 2, CG = 2, WG = 5;

  logic       CLK = 1'b0, RST = 1'b0, key_in = 1'b0;
  logic [7:0] char_out;
  logic       char_valid, err, busy;

  morse_receptor #(.UNIT_CLKS(U), .DASH_MIN(DM), .CHAR_GAP(CG), .WORD_GAP(WG)) dut (
    .CLK(CLK), .RST(RST), .key_in(key_in),
    .char_out(char_out), .char_valid(char_valid), .err(err), .busy(busy));

  always #5 CLK = ~CLK;

  typedef struct {logic [7:0] ch; logic e; int cyc;} exp_t;
  exp_t       expq[$];
  int         total = 0, bad = 0, cyc = 0;
  logic [7:0] mmap[string];
  string      sym = "";
  string letters[26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                         ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                         "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--.."};
  string digits[10] = '{"-----", ".----", "..---", "...--", "....-", ".....", "-....",
                        "--...", "---..", "----."};

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(string name, int act, int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d (cyc %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference model: a mark of n clocks is n/U units; a space closes the symbol
  // once it spans CHAR_GAP units and adds a separator once it exceeds WORD_GAP units.
  function automatic void model_mark(int n);
    string e;
    if (n / U == 0) return;
    e = (n / U >= DM) ? "-" : ".";
    sym = {sym, e};
  endfunction

  function automatic void model_space(int n, int c0);
    exp_t x;
    if (sym.len() == 0 || n < CG * U) return;
    x.ch  = mmap.exists(sym) ? mmap[sym] : 8'h3F;
    x.e   = (x.ch == 8'h3F);
    x.cyc = c0 + CG * U + 1;
    expq.push_back(x);
    sym = "";
    if (n > WG * U) begin
      x.ch = 8'h20; x.e = 1'b0; x.cyc = c0 + WG * U + 1;
      expq.push_back(x);
    end
  endfunction

  task automatic drive(logic v, int n);
    key_in = v;
    repeat (n) @(negedge CLK);
  endtask

  task automatic mark(int n);
    model_mark(n);
    key_in = 1'b1;
    @(negedge CLK);
    check("busy_in_mark", int'(busy), 1);
    repeat (n - 1) @(negedge CLK);
  endtask

  task automatic space(int n);
    model_space(n, cyc);
    drive(1'b0, n);
  endtask

  task automatic send(string s, int gap, bit glitches);
    byte b;
    for (int i = 0; i < s.len(); i++) begin
      b = s[i];
      if (b == 8'h2E) mark(int'($urandom_range(4, 7)));
      else            mark(int'($urandom_range(8, 30)));
      if (i < s.len() - 1) begin
        if (glitches && $urandom_range(0, 3) == 0) begin
          space(int'($urandom_range(1, 7)));
          mark(int'($urandom_range(1, 3)));
          space(int'($urandom_range(1, 7)));
        end else begin
          space(int'($urandom_range(4, 7)));
        end
      end
    end
    space(gap);
  endtask

  initial begin
    exp_t x;
    forever begin
      @(posedge CLK);
      #1;
      if (err && !char_valid) check("err_without_valid", 1, 0);
      if (char_valid) begin
        if (expq.size() == 0) begin
          check("unexpected_char", int'(char_out), 256);
        end else begin
          x = expq.pop_front();
          check("char", int'(char_out), int'(x.ch));
          check("err", int'(err), int'(x.e));
          check("arrival_cyc", cyc, x.cyc);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    string s, e;
    int n;
    foreach (letters[i]) mmap[letters[i]] = 8'h41 + 8'(i);
    foreach (digits[i])  mmap[digits[i]]  = 8'h30 + 8'(i);

    repeat (3) @(negedge CLK);
    check("rst_char", int'(char_out), 0);
    check("rst_valid", int'(char_valid), 0);
    check("rst_err", int'(err), 0);
    check("rst_busy", int'(busy), 0);
    RST = 1'b1;
    drive(1'b0, 5);

    // Single dot, then a full word gap
    mark(4); space(28);
    send(".-", 12, 0); send("-", 12, 0);
    send("...", 12, 0); send("---", 12, 0); send("...", 28, 0);
    send(".....", 12, 0); send("-----", 12, 0);
    mark(40); space(28);
    send("......", 12, 0); send("..--", 28, 0);
    // Glitch between two dots
    mark(4); space(4); mark(2); space(4); mark(4); space(28);
    // Dot/dash and glitch thresholds
    mark(7); space(12); mark(8); space(12);
    mark(3); space(4); mark(4); space(12);
    // Gap thresholds: 7 continues, 8 closes, 20 no separator, 21 separator
    mark(4); space(7); mark(4); space(8);
    mark(4); space(20); mark(4); space(21);

    // Reset mid-symbol with the key held high across release
    mark(12); space(4); mark(12); space(3);
    key_in = 1'b1;
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    check("midrst_char", int'(char_out), 0);
    check("midrst_busy", int'(busy), 0);
    RST = 1'b1;
    sym = "";
    drive(1'b1, 30);
    check("held_high_busy", int'(busy), 0);
    space(10);
    send(".", 28, 0);

    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 9) < 7) begin
        n = int'($urandom_range(0, 35));
        s = (n < 26) ? letters[n] : digits[n - 26];
      end else begin
        s = "";
        n = int'($urandom_range(1, 6));
        for (int j = 0; j < n; j++) begin
          e = ($urandom_range(0, 1) == 1) ? "-" : ".";
          s = {s, e};
        end
      end
      if (k == 39)                       send(s, 40, 1);
      else if ($urandom_range(0, 9) < 7) send(s, int'($urandom_range(8, 20)), 1);
      else                               send(s, int'($urandom_range(21, 40)), 1);
    end

    check("queue_drained", expq.size(), 0);
    check("final_busy", int'(busy), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/morse_receptor.md
Name: morse_receptor

Overview:
- Receiving end of the Morse link: samples a keyed tone/line level, measures mark and space durations in Morse time units, classifies dots, dashes and gaps, and decodes each completed symbol to an 8-bit ASCII character with a one-cycle valid pulse.
- Sits after the line synchronizer/debouncer and feeds the display/UART side of the design.
- Uses the same 5-element symbol limit as the transmitter: letters A–Z and digits 0–9.

Parameters:
- UNIT_CLKS, 5000000, clock cycles per Morse unit (simulation uses 4).
- DASH_MIN, 2, minimum mark length in units classified as dash.
- CHAR_GAP, 2, space length in units that closes a character.
- WORD_GAP, 5, space length in units that emits a word separator.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  synchronous reset, active-low (RST=0 clears the block on the next CLK edge).
- key_in  in  1  synchronized, debounced line level; 1 = mark (tone), 0 = space.
- char_out  out  8  decoded ASCII character; holds last value between pulses.
- char_valid  out  1  one-cycle pulse; char_out is valid in this cycle.
- err  out  1  one-cycle pulse coincident with char_valid when the symbol is undecodable.
- busy  out  1  high while a symbol is being assembled (state MARK or GAP).

Behaviour:
- Reset (RST=0 at CLK edge): state=IDLE; char_out=8'h00; char_valid=0; err=0; busy=0; pattern, element count, unit counters and overflow flag cleared; key_d=1.
- key_d resetting to 1 means a key held high through reset release produces no rising edge. The block waits for a low and then a rise.
- Edge detect: rise = key_in & ~key_d; fall = ~key_in & key_d.
- Prescaler: 0..UNIT_CLKS-1; restarts at 0 on every rise/fall. unit_tick pulses when it wraps.
- len: 3-bit unit counter. Cleared on each edge, +1 per unit_tick, saturates at 7.
- States:
  - IDLE: busy=0. On rise -> MARK.
  - MARK: on fall, classify len:
    - len=0: glitch. Discard. Go to GAP if count>0, else IDLE.
    - 1 <= len < DASH_MIN: dot (bit 0).
    - len >= DASH_MIN: dash (bit 1).
    - For a dot or dash: if count<5, pattern[4-count]=bit and count+1; if count=5, set ovf. Then -> GAP.
  - GAP: a rise -> MARK (same symbol). When len reaches CHAR_GAP, emit the character (below), clear pattern/count/ovf, -> WGAP.
  - WGAP: busy=0. A rise -> MARK (new symbol, no word separator). When len reaches WORD_GAP, emit char_out=8'h20 with char_valid=1, -> IDLE.
  - Separator rule: at most one 8'h20 per gap; no separator follows a reset or an err-only start.
- Emit timing: char_valid/char_out/err are registered and asserted in the cycle after the unit_tick that completes the gap. Latency from the key fall to char_valid is CHAR_GAP*UNIT_CLKS+1 cycles.
- Decode table: (count, pattern MSB-first), standard ITU Morse, A–Z -> 8'h41–8'h5A, 0–9 -> 8'h30–8'h39.
- Any unlisted pattern, or ovf=1: char_out=8'h3F ('?'), err=1, char_valid=1.
- Simultaneous events:
  - A rise in the same cycle as the CHAR_GAP tick: emit first, then enter MARK of the new symbol.
  - A rise in the same cycle as the WORD_GAP tick: separator suppressed, new symbol started.
- Reset mid-operation: partial symbol discarded, no pulse emitted.

Test Plan:
1. UNIT_CLKS=4. Mark 4 clks, then low -> char_valid 9 clks after fall with char_out=8'h45 ('E'), err=0. Then 8'h20 after 5 units total space.
2. ".-" / "-" / "...---..." as separate symbols, with 3-unit char gaps -> 8'h41, 8'h54, 8'h53 8'h4F 8'h53. No 8'h20 between any of them.
3. "....." and "-----" -> 8'h35 and 8'h30. Mark of 7+ units still decodes as dash.
4. Six dots -> single pulse, char_out=8'h3F, err=1. "..--" (unlisted) -> 8'h3F, err=1.
5. Mark of 2 clks (len=0) between dot gaps -> ignored. ". <glitch> ." decodes to 'I' (8'h49).
6. RST=0 after two dashes mid-symbol -> outputs 0, busy=0, no char_valid.
   - Key held high across RST release -> nothing until a fall then rise.
   - Next "." decodes to 'E'.
